// File: rtl/rtc_pkg.sv
// Shared constants and helpers for the BCD real-time clock.
// Time is always held as 24h BCD; conversion happens only for display.
package rtc_pkg;

  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam logic [3:0] UNITS_MAX    = 4'd9;
  localparam logic [7:0] MS_MAX       = 8'h59;
  localparam logic [7:0] HR_MAX       = 8'h23;
  localparam logic [7:0] HR_NOON      = 8'h12;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [9:0][6:0] SEG_PAT = {
    7'h7B, 7'h7F, 7'h70, 7'h5F, 7'h5B,
    7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
  };

  function automatic logic bcd_valid_time(
    input logic [7:0] hr,
    input logic [7:0] mn,
    input logic [7:0] sc
  );
    return (hr[3:0] <= UNITS_MAX) &&
           (mn[3:0] <= UNITS_MAX) &&
           (sc[3:0] <= UNITS_MAX) &&
           (mn[7:4] <= SEC_TENS_MAX) &&
           (sc[7:4] <= SEC_TENS_MAX) &&
           (hr <= HR_MAX);
  endfunction

  function automatic logic [7:0] hr24_to_12(input logic [7:0] hr);
    logic [4:0] b;
    b = 5'(hr[7:4]) * 5'd10 + 5'(hr[3:0]);
    if (b == 5'd0) b = 5'd12;
    else if (b > 5'd12) b = b - 5'd12;
    return {4'(b / 5'd10), 4'(b % 5'd10)};
  endfunction

endpackage

// File: rtl/rtc_seg7_decode.sv
// One BCD digit to 7-segment {a..g} pattern, bit6 = a.
// Non-BCD digits blank; polarity folded in so blank means all off.
import rtc_pkg::*;

module rtc_seg7_decode #(
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  logic [6:0] pat;

  always_comb begin
    pat = SEG_BLANK;
    if (digit_i <= UNITS_MAX) pat = SEG_PAT[digit_i];
  end

  assign seg_o = pat ^ {7{SEG_ACTIVE_LOW}};

endmodule

// File: rtl/rtc_bcd_timekeeper.sv
// BCD real-time clock: prescaler, 24h BCD counter chain, validated
// time-set, HH:MM alarm, 12/24h display and per-digit 7-seg drive.
import rtc_pkg::*;

module rtc_bcd_timekeeper #(
  parameter int TICK_DIV       = 50_000_000,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic       set_valid,
  input  logic [7:0] set_hr,
  input  logic [7:0] set_min,
  input  logic [7:0] set_sec,
  input  logic       mode_12h,
  input  logic       alarm_en,
  input  logic [7:0] alarm_hr,
  input  logic [7:0] alarm_min,
  output logic [3:0] hr_m,
  output logic [3:0] hr_l,
  output logic [3:0] min_m,
  output logic [3:0] min_l,
  output logic [3:0] sec_m,
  output logic [3:0] sec_l,
  output logic       pm,
  output logic [6:0] seg_hr_m,
  output logic [6:0] seg_hr_l,
  output logic [6:0] seg_min_m,
  output logic [6:0] seg_min_l,
  output logic [6:0] seg_sec_m,
  output logic [6:0] seg_sec_l,
  output logic       sec_tick,
  output logic       day_wrap,
  output logic       alarm_hit,
  output logic       set_err
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] hr_q, min_q, sec_q;
  logic [7:0] hr_d, min_d, sec_d;
  logic [7:0] hr_n, min_n, sec_n;
  logic sec_tick_q, day_wrap_q, alarm_hit_q, set_err_q;
  logic sec_tick_d, day_wrap_d, alarm_hit_d, set_err_d;
  logic tick, set_ok, alarm_ok;

  function automatic logic [7:0] inc60(input logic [7:0] v);
    if (v == MS_MAX) return 8'h00;
    if (v[3:0] == UNITS_MAX) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  assign tick     = en && (cnt_q == CNT_MAX);
  assign set_ok   = set_valid && bcd_valid_time(set_hr, set_min, set_sec);
  assign alarm_ok = bcd_valid_time(alarm_hr, alarm_min, 8'h00);

  always_comb begin
    sec_n = inc60(sec_q);
    min_n = (sec_q == MS_MAX) ? inc60(min_q) : min_q;
    hr_n  = hr_q;
    if (sec_q == MS_MAX && min_q == MS_MAX) begin
      if (hr_q == HR_MAX) hr_n = 8'h00;
      else if (hr_q[3:0] == UNITS_MAX) hr_n = {hr_q[7:4] + 4'd1, 4'd0};
      else hr_n = {hr_q[7:4], hr_q[3:0] + 4'd1};
    end
  end

  // A set strobe, valid or not, takes priority over a coincident tick
  always_comb begin
    cnt_d       = cnt_q;
    hr_d        = hr_q;
    min_d       = min_q;
    sec_d       = sec_q;
    sec_tick_d  = 1'b0;
    day_wrap_d  = 1'b0;
    alarm_hit_d = 1'b0;
    set_err_d   = 1'b0;
    if (en) cnt_d = tick ? '0 : cnt_q + CW'(1);
    if (set_valid) begin
      if (set_ok) begin
        cnt_d = '0;
        hr_d  = set_hr;
        min_d = set_min;
        sec_d = set_sec;
      end else begin
        set_err_d = 1'b1;
      end
    end else if (tick) begin
      hr_d        = hr_n;
      min_d       = min_n;
      sec_d       = sec_n;
      sec_tick_d  = 1'b1;
      day_wrap_d  = ({hr_q, min_q, sec_q} == {HR_MAX, MS_MAX, MS_MAX});
      alarm_hit_d = alarm_en && alarm_ok &&
                    ({hr_n, min_n, sec_n} == {alarm_hr, alarm_min, 8'h00});
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q       <= '0;
      hr_q        <= 8'h00;
      min_q       <= 8'h00;
      sec_q       <= 8'h00;
      sec_tick_q  <= 1'b0;
      day_wrap_q  <= 1'b0;
      alarm_hit_q <= 1'b0;
      set_err_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      hr_q        <= hr_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      sec_tick_q  <= sec_tick_d;
      day_wrap_q  <= day_wrap_d;
      alarm_hit_q <= alarm_hit_d;
      set_err_q   <= set_err_d;
    end
  end

  assign sec_tick  = sec_tick_q;
  assign day_wrap  = day_wrap_q;
  assign alarm_hit = alarm_hit_q;
  assign set_err   = set_err_q;

  logic [7:0] hr_disp;
  assign hr_disp = mode_12h ? hr24_to_12(hr_q) : hr_q;
  assign pm      = (hr_q >= HR_NOON);

  assign {hr_m, hr_l}   = hr_disp;
  assign {min_m, min_l} = min_q;
  assign {sec_m, sec_l} = sec_q;

  logic [23:0] digits;
  logic [41:0] segs;
  assign digits = {hr_m, hr_l, min_m, min_l, sec_m, sec_l};

  for (genvar g = 0; g < 6; g++) begin : g_seg
    rtc_seg7_decode #(
      .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
    ) u_seg (
      .digit_i(digits[g*4 +: 4]),
      .seg_o  (segs[g*7 +: 7])
    );
  end

  assign {seg_hr_m, seg_hr_l, seg_min_m,
          seg_min_l, seg_sec_m, seg_sec_l} = segs;

endmodule

// File: tb/tb_rtc_bcd_timekeeper.sv
// Directed vector table plus hand sequences for rtc_bcd_timekeeper
// with TICK_DIV=4 and active-high segments.
module tb_rtc_bcd_timekeeper;

  logic       clk, reset_n, en, set_valid, mode_12h, alarm_en;
  logic [7:0] set_hr, set_min, set_sec, alarm_hr, alarm_min;
  logic [3:0] hr_m, hr_l, min_m, min_l, sec_m, sec_l;
  logic       pm, sec_tick, day_wrap, alarm_hit, set_err;
  logic [6:0] seg_hr_m, seg_hr_l, seg_min_m;
  logic [6:0] seg_min_l, seg_sec_m, seg_sec_l;

  rtc_bcd_timekeeper #(
    .TICK_DIV(4),
    .SEG_ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .en(en),
    .set_valid(set_valid), .set_hr(set_hr),
    .set_min(set_min), .set_sec(set_sec),
    .mode_12h(mode_12h), .alarm_en(alarm_en),
    .alarm_hr(alarm_hr), .alarm_min(alarm_min),
    .hr_m(hr_m), .hr_l(hr_l), .min_m(min_m),
    .min_l(min_l), .sec_m(sec_m), .sec_l(sec_l),
    .pm(pm),
    .seg_hr_m(seg_hr_m), .seg_hr_l(seg_hr_l),
    .seg_min_m(seg_min_m), .seg_min_l(seg_min_l),
    .seg_sec_m(seg_sec_m), .seg_sec_l(seg_sec_l),
    .sec_tick(sec_tick), .day_wrap(day_wrap),
    .alarm_hit(alarm_hit), .set_err(set_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         do_set;
    logic [7:0] sh, sm, ss;
    bit         en, m12, aen;
    logic [7:0] ah, am;
    int         ncyc;
    logic [23:0] exp_t;
    bit         exp_pm;
    int         exp_tk, exp_dw, exp_ah, exp_err;
  } vec_t;

  localparam int NV = 14;
  vec_t tbl [NV];

  logic [6:0] segtab [10];
  int n_vec = 0;
  int n_mis = 0;
  int tk, dw, ah, er;

  task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
    n_vec++;
    if (a !== e) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (sec_tick)  tk++;
    if (day_wrap)  dw++;
    if (alarm_hit) ah++;
    if (set_err)   er++;
  endtask

  function automatic logic [41:0] segs_of(logic [23:0] t);
    logic [41:0] r;
    logic [3:0]  d;
    for (int i = 0; i < 6; i++) begin
      d = t[i*4 +: 4];
      r[i*7 +: 7] = segtab[d];
    end
    return r;
  endfunction

  function automatic vec_t mk(bit s, logic [23:0] st, bit e, bit m,
                              bit ae, logic [15:0] al, int n,
                              logic [23:0] xt, bit xp, int xtk,
                              int xdw, int xah, int xer);
    vec_t v;
    v.do_set = s;
    {v.sh, v.sm, v.ss} = st;
    v.en = e; v.m12 = m; v.aen = ae;
    {v.ah, v.am} = al;
    v.ncyc = n;
    v.exp_t = xt; v.exp_pm = xp;
    v.exp_tk = xtk; v.exp_dw = xdw;
    v.exp_ah = xah; v.exp_err = xer;
    return v;
  endfunction

  function automatic logic [23:0] disp();
    return {hr_m, hr_l, min_m, min_l, sec_m, sec_l};
  endfunction

  function automatic logic [41:0] segs_now();
    return {seg_hr_m, seg_hr_l, seg_min_m,
            seg_min_l, seg_sec_m, seg_sec_l};
  endfunction

  initial begin
    segtab = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
               7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

    //            set set_time   en m12 aen alarm    n   exp_t     pm tk dw ah er
    tbl[0]  = mk(0, 24'h000000, 1, 0, 0, 16'h0000, 40, 24'h000010, 0, 10, 0, 0, 0);
    tbl[1]  = mk(1, 24'h235958, 1, 0, 0, 16'h0000, 8,  24'h000000, 0, 2, 1, 0, 0);
    tbl[2]  = mk(1, 24'h240000, 1, 0, 0, 16'h0000, 0,  24'h000000, 0, 0, 0, 0, 1);
    tbl[3]  = mk(1, 24'h00005A, 1, 0, 0, 16'h0000, 0,  24'h000000, 0, 0, 0, 0, 1);
    tbl[4]  = mk(1, 24'h003000, 1, 1, 0, 16'h0000, 0,  24'h123000, 0, 0, 0, 0, 0);
    tbl[5]  = mk(1, 24'h130500, 1, 1, 0, 16'h0000, 0,  24'h010500, 1, 0, 0, 0, 0);
    tbl[6]  = mk(1, 24'h120000, 1, 1, 0, 16'h0000, 0,  24'h120000, 1, 0, 0, 0, 0);
    tbl[7]  = mk(1, 24'h230000, 1, 1, 0, 16'h0000, 4,  24'h110001, 1, 1, 0, 0, 0);
    tbl[8]  = mk(1, 24'h065959, 1, 0, 1, 16'h0700, 4,  24'h070000, 0, 1, 0, 1, 0);
    tbl[9]  = mk(1, 24'h070000, 1, 0, 1, 16'h0700, 3,  24'h070000, 0, 0, 0, 0, 0);
    tbl[10] = mk(1, 24'h065959, 1, 0, 0, 16'h0700, 4,  24'h070000, 0, 1, 0, 0, 0);
    tbl[11] = mk(0, 24'h000000, 0, 0, 0, 16'h0700, 20, 24'h070000, 0, 0, 0, 0, 0);
    tbl[12] = mk(1, 24'h095959, 0, 0, 1, 16'h1000, 5,  24'h095959, 0, 0, 0, 0, 0);
    tbl[13] = mk(0, 24'h000000, 1, 0, 1, 16'h1000, 4,  24'h100000, 0, 1, 0, 1, 0);

    reset_n = 1'b0; en = 1'b0; set_valid = 1'b0;
    set_hr = 8'h00; set_min = 8'h00; set_sec = 8'h00;
    mode_12h = 1'b0; alarm_en = 1'b0;
    alarm_hr = 8'h00; alarm_min = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset time", 64'(disp()), 64'h000000);
    chk("reset pulses", 64'({pm, sec_tick, day_wrap, alarm_hit, set_err}), 64'h0);
    mode_12h = 1'b1;
    #1;
    chk("reset 12h hr", 64'({hr_m, hr_l}), 64'h12);
    mode_12h = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      en = tbl[i].en; mode_12h = tbl[i].m12;
      alarm_en = tbl[i].aen;
      alarm_hr = tbl[i].ah; alarm_min = tbl[i].am;
      tk = 0; dw = 0; ah = 0; er = 0;
      if (tbl[i].do_set) begin
        set_hr = tbl[i].sh; set_min = tbl[i].sm;
        set_sec = tbl[i].ss; set_valid = 1'b1;
        step();
        set_valid = 1'b0;
      end
      repeat (tbl[i].ncyc) step();
      chk($sformatf("v%0d time", i), 64'(disp()), 64'(tbl[i].exp_t));
      chk($sformatf("v%0d pm", i), 64'(pm), 64'(tbl[i].exp_pm));
      chk($sformatf("v%0d ticks", i), 64'(tk), 64'(tbl[i].exp_tk));
      chk($sformatf("v%0d day_wrap", i), 64'(dw), 64'(tbl[i].exp_dw));
      chk($sformatf("v%0d alarm", i), 64'(ah), 64'(tbl[i].exp_ah));
      chk($sformatf("v%0d set_err", i), 64'(er), 64'(tbl[i].exp_err));
      chk($sformatf("v%0d segs", i), 64'(segs_now()),
          64'(segs_of(tbl[i].exp_t)));
    end

    // valid set landing on the tick cycle: tick lost, prescaler restarts
    en = 1'b1; mode_12h = 1'b0; alarm_en = 1'b0;
    set_hr = 8'h01; set_min = 8'h02; set_sec = 8'h03;
    set_valid = 1'b1;
    step();
    set_valid = 1'b0;
    repeat (3) step();
    tk = 0;
    set_hr = 8'h05; set_min = 8'h06; set_sec = 8'h07;
    set_valid = 1'b1;
    step();
    set_valid = 1'b0;
    chk("tickset time", 64'(disp()), 64'h050607);
    chk("tickset no tick", 64'(sec_tick), 64'h0);
    repeat (3) step();
    chk("tickset quiet 3", 64'(tk), 64'h0);
    step();
    chk("tickset tick 4", 64'(sec_tick), 64'h1);
    chk("tickset adv", 64'(disp()), 64'h050608);

    // async reset between edges while sec_tick is high
    mode_12h = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    chk("async tick drop", 64'(sec_tick), 64'h0);
    chk("async time", 64'(disp()), 64'h120000);
    chk("async pm", 64'(pm), 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
